// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO register and divide unit.
package hilo_div_unit_pkg;

    localparam int DIV_STEPS_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // ALU control codes decode uses to raise div_start / div_signed together.
    localparam logic [3:0] DIV_CONTROL  = 4'b1010;
    localparam logic [3:0] DIVU_CONTROL = 4'b1011;

    // Magnitude of a 32-bit operand when treated as signed; raw value otherwise.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Iterative restoring divider: one quotient bit per cycle, sign fix-up on output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// DIV_IDLE | waiting for start; operands latched as magnitudes on start
// DIV_CALC | one restoring subtract/shift step per cycle
// DIV_DONE | signed result presented for one cycle, written into HI/LO
module hilo_div_unit_div_core
    import hilo_div_unit_pkg::*;
#(
    parameter int STEPS = DIV_STEPS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [31:0]   rem;
    logic [31:0]   dvd;      // dividend shifts out the top, quotient shifts in the bottom
    logic [31:0]   dvs;
    logic          sign_q;
    logic          sign_r;
    logic [32:0]   trial;

    // Trial subtract of the shifted partial remainder against the divisor.
    always_comb begin
        trial = {rem, dvd[31]} - {1'b0, dvs};
    end

    // Divider FSM, counter and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            rem    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else if (flush) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            // Divide by zero: all-ones quotient, dividend as remainder.
                            rem    <= a;
                            dvd    <= '1;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                            state  <= DIV_DONE;
                        end else begin
                            rem    <= '0;
                            dvd    <= abs_if(a, is_signed);
                            dvs    <= abs_if(b, is_signed);
                            sign_q <= is_signed & (a[31] ^ b[31]);
                            sign_r <= is_signed & a[31];
                            cnt    <= '0;
                            state  <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        dvd <= {dvd[30:0], 1'b1};
                    end else begin
                        rem <= {rem[30:0], dvd[31]};
                        dvd <= {dvd[30:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    // Result sign fix-up and status; done is withheld when the divide is flushed.
    always_comb begin
        quotient  = sign_q ? (~dvd + 32'd1) : dvd;
        remainder = sign_r ? (~rem + 32'd1) : rem;
        done      = (state == DIV_DONE) && !flush;
        busy      = ((state == DIV_IDLE) && start) || (state == DIV_CALC);
    end

endmodule

// File: rtl/hilo_div_unit.sv
// Architectural HI/LO pair: ALU writes, divider writeback and same-cycle read bypass.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int DIV_STEPS = DIV_STEPS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] quotient;
    logic [31:0] remainder;

    hilo_div_unit_div_core #(
        .STEPS (DIV_STEPS)
    ) u_div_core (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .start     (div_start),
        .is_signed (div_signed),
        .a         (div_a),
        .b         (div_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // HI/LO update; a landing divide result wins over ALU writes to both registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (div_done) begin
            hi_q <= remainder;
            lo_q <= quotient;
        end else begin
            if (we_hi) hi_q <= hi_in;
            if (we_lo) lo_q <= lo_in;
        end
    end

    // Bypass so MFHI/MFLO in the same cycle as MTHI/MTLO/MULT sees the new value.
    always_comb begin
        hi_out = we_hi ? hi_in : hi_q;
        lo_out = we_lo ? lo_in : lo_q;
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: divide scoreboard, ALU writes, flush and reset.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_busy;
    logic        div_done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hilo_div_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .we_hi      (we_hi),
        .we_lo      (we_lo),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    // Reference divide using 64-bit arithmetic (truncating, remainder follows dividend).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint sa, sd, q, r;
        if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
        end else if (s) begin
            sa   = $signed(a);
            sd   = $signed(b);
            q    = sa / sd;
            r    = sa % sd;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    task automatic idle_inputs();
        flush      = 1'b0;
        we_hi      = 1'b0;
        we_lo      = 1'b0;
        hi_in      = '0;
        lo_in      = '0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_a      = '0;
        div_b      = '0;
    endtask

    task automatic alu_write(input logic [31:0] h, input logic [31:0] l);
        @(posedge clk); #1;
        we_hi = 1'b1; we_lo = 1'b1; hi_in = h; lo_in = l;
        @(posedge clk); #1;
        we_hi = 1'b0; we_lo = 1'b0;
    endtask

    // Runs one divide from the next cycle, checking busy each cycle, done timing and result.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input string name, input bit hold_start);
        exp_t e;
        int   done_cyc;
        int   exp_cyc;
        int   cyc;
        exp_cyc  = (b == 32'd0) ? 1 : 33;
        done_cyc = -1;
        cyc      = 0;
        @(posedge clk); #1;
        flush = 1'b0; div_a = a; div_b = b; div_signed = s; div_start = 1'b1;
        sb.push_back(model(a, b, s));
        while (done_cyc < 0 && cyc < 100) begin
            @(negedge clk);
            vectors++;
            if (div_busy !== (cyc < exp_cyc)) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, cyc, div_busy, (cyc < exp_cyc));
            end
            if (div_done) done_cyc = cyc;
            @(posedge clk); #1;
            if (!hold_start || done_cyc >= 0) div_start = 1'b0;
            if (hold_start) div_a = 32'd50;
            cyc++;
        end
        div_start = 1'b0;
        vectors++;
        if (done_cyc != exp_cyc) begin
            miscompares++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_cyc);
        end
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (hi_out !== e.hi || lo_out !== e.lo) begin
            miscompares++;
            $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi_out, lo_out, e.hi, e.lo);
        end
    endtask

    // Starts a nonzero-divisor DIVU and returns just after the edge entering the DONE cycle.
    task automatic div_to_done(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        div_a = a; div_b = b; div_signed = 1'b0; div_start = 1'b1;
        repeat (33) begin
            @(posedge clk); #1;
            div_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({div_busy, div_done, hi_out, lo_out} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want all 0", div_busy, div_done, hi_out, lo_out);
        end
        resetn = 1'b1;
    endtask

    task automatic test_alu_write();
        @(posedge clk); #1;
        we_hi = 1'b1; hi_in = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++;
        if (hi_out !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL mthi_bypass: got %h want deadbeef", hi_out);
        end
        @(posedge clk); #1;
        we_hi = 1'b0; hi_in = '0;
        @(negedge clk);
        vectors++;
        if (hi_out !== 32'hDEAD_BEEF || lo_out !== 32'd0) begin
            miscompares++;
            $display("FAIL mthi_registered: got hi=%h lo=%h want hi=deadbeef lo=0", hi_out, lo_out);
        end
        alu_write(32'd1, 32'd2);
        @(negedge clk);
        vectors++;
        if (hi_out !== 32'd1 || lo_out !== 32'd2) begin
            miscompares++;
            $display("FAIL mult_write: got hi=%h lo=%h want hi=1 lo=2", hi_out, lo_out);
        end
    endtask

    task automatic test_divide();
        run_div(32'd100, 32'd7, 1'b0, "divu_100_7", 1'b0);
        run_div(-32'sd7, 32'd2, 1'b1, "div_m7_2", 1'b0);
        run_div(32'd7, -32'sd2, 1'b1, "div_7_m2", 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_min_m1", 1'b0);
        run_div(32'd5, 32'd0, 1'b0, "divu_5_0", 1'b0);
        run_div(32'hFFFF_FFFF, 32'd3, 1'b0, "divu_max_3", 1'b0);
        run_div(32'hFFFF_FFF0, 32'hFFFF_FFFD, 1'b1, "div_m16_m3", 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_div($urandom, $urandom_range(1, 32'h0001_0000), 1'(i % 2), "div_random", 1'b0);
        end
    endtask

    task automatic test_start_ignored();
        run_div(32'd100, 32'd7, 1'b0, "start_held", 1'b1);
    endtask

    task automatic test_flush_calc();
        alu_write(32'h1111_1111, 32'h2222_2222);
        @(posedge clk); #1;
        div_a = 32'd100; div_b = 32'd7; div_signed = 1'b0; div_start = 1'b1;
        repeat (11) begin
            @(posedge clk); #1;
            div_start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (div_done !== 1'b0 || hi_out !== 32'h1111_1111 || lo_out !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL flush_calc: got done=%b hi=%h lo=%h want done=0 hi=11111111 lo=22222222", div_done, hi_out, lo_out);
        end
        run_div(32'd100, 32'd7, 1'b0, "restart_after_flush", 1'b0);
    endtask

    task automatic test_flush_done();
        alu_write(32'h3333_3333, 32'h4444_4444);
        div_to_done(32'd100, 32'd7);
        flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (div_done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_done_pulse: got %b want 0", div_done);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (hi_out !== 32'h3333_3333 || lo_out !== 32'h4444_4444 || div_busy !== 1'b0 || div_done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_done_hilo: got hi=%h lo=%h busy=%b done=%b want hi=33333333 lo=44444444 busy=0 done=0",
                     hi_out, lo_out, div_busy, div_done);
        end
    endtask

    task automatic test_done_priority();
        div_to_done(32'd100, 32'd7);
        we_lo = 1'b1; lo_in = 32'd9;
        @(negedge clk);
        vectors++;
        if (div_done !== 1'b1) begin
            miscompares++;
            $display("FAIL priority_done: got %b want 1", div_done);
        end
        @(posedge clk); #1;
        we_lo = 1'b0; lo_in = '0;
        @(negedge clk);
        vectors++;
        if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
            miscompares++;
            $display("FAIL priority_result: got hi=%h lo=%h want hi=2 lo=14", hi_out, lo_out);
        end
    endtask

    task automatic test_reset_mid();
        alu_write(32'h5555_5555, 32'h6666_6666);
        @(posedge clk); #1;
        div_a = 32'd100; div_b = 32'd7; div_signed = 1'b0; div_start = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            div_start = 1'b0;
        end
        #1 resetn = 1'b0;
        #1;
        vectors++;
        if ({div_busy, div_done, hi_out, lo_out} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all 0", div_busy, div_done, hi_out, lo_out);
        end
        @(negedge clk);
        resetn = 1'b1;
        run_div(32'd100, 32'd7, 1'b0, "after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        run_div(32'd1000, 32'd10, 1'b0, "b2b_first", 1'b0);
        run_div(-32'sd1000, 32'd7, 1'b1, "b2b_second", 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_divide();
        test_start_ignored();
        test_flush_calc();
        test_flush_done();
        test_done_priority();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
